// File: rtl/dds_pkg.sv
// Shared constants, wave encodings and parser state type for the DDS command path.
package dds_pkg;

  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [3:0] OP_FREQ  = 4'h1;
  localparam logic [3:0] OP_PHASE = 4'h2;
  localparam logic [3:0] OP_WAVE  = 4'h3;
  localparam logic [3:0] OP_SYNC  = 4'h4;

  localparam logic [3:0] WAVE_OFF = 4'b0000;
  localparam logic [3:0] WAVE_SIN = 4'b0001;
  localparam logic [3:0] WAVE_SQU = 4'b0010;
  localparam logic [3:0] WAVE_TRI = 4'b0100;
  localparam logic [3:0] WAVE_SAW = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAY,
    CK,
    APPLY
  } state_t;

  function automatic logic wave_legal(input logic [3:0] w);
    return (w == WAVE_OFF) || (w == WAVE_SIN) || (w == WAVE_SQU) ||
           (w == WAVE_TRI) || (w == WAVE_SAW);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_FREQ) || (op == OP_PHASE) || (op == OP_WAVE) || (op == OP_SYNC);
  endfunction

endpackage

// File: rtl/dds_chan_regs.sv
// One DDS channel's control registers; written only by a validated frame.
module dds_chan_regs
  import dds_pkg::*;
#(
  parameter logic [31:0] FREQ_RST  = 32'd42949,
  parameter logic [9:0]  PHASE_RST = 10'd0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        we,
  input  logic [3:0]  op,
  input  logic [31:0] payload,
  output logic [31:0] freq_ctrl,
  output logic [9:0]  phase_ctrl,
  output logic [3:0]  wave_sel
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      freq_ctrl  <= FREQ_RST;
      phase_ctrl <= PHASE_RST;
      wave_sel   <= WAVE_OFF;
    end else if (we) begin
      case (op)
        OP_FREQ:  freq_ctrl  <= payload;
        OP_PHASE: phase_ctrl <= payload[9:0];
        OP_WAVE:  wave_sel   <= payload[3:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/dds_cmd_parser.sv
// Framed UART command decoder (A5, CMD, 4-byte payload, XOR checksum) driving two DDS channels.
module dds_cmd_parser
  import dds_pkg::*;
#(
  parameter logic [31:0] FREQ_RST    = 32'd42949,
  parameter logic [9:0]  PHASE_RST   = 10'd0,
  parameter logic [23:0] TIMEOUT_CYC = 24'd240000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] freq_ctrl_a,
  output logic [31:0] freq_ctrl_b,
  output logic [9:0]  phase_ctrl_a,
  output logic [9:0]  phase_ctrl_b,
  output logic [3:0]  wave_sel_a,
  output logic [3:0]  wave_sel_b,
  output logic        fre_add_r_a,
  output logic        fre_add_r_b,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [7:0]  cmd_q;
  logic [31:0] pay_q;
  logic [7:0]  ck_acc;
  logic [1:0]  byte_cnt;
  logic [23:0] tcnt;
  logic        timeout;
  logic        frame_good;
  logic        err_nxt;

  assign timeout = (state inside {CMD, PAY, CK}) && (tcnt == TIMEOUT_CYC);

  assign frame_good = (ck_acc == rx_data) && (cmd_q[7:5] == 3'b000) &&
                      op_legal(cmd_q[3:0]) &&
                      ((cmd_q[3:0] != OP_WAVE) || wave_legal(pay_q[3:0]));

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    if (timeout) begin
      // a byte landing on the timeout edge is discarded with the partial frame
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE, APPLY: state_nxt = (rx_valid && rx_data == HDR) ? CMD : IDLE;
        CMD:         if (rx_valid) state_nxt = PAY;
        PAY:         if (rx_valid && byte_cnt == 2'd3) state_nxt = CK;
        CK: begin
          if (rx_valid) begin
            state_nxt = frame_good ? APPLY : IDLE;
            err_nxt   = !frame_good;
          end
        end
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      tcnt        <= 24'd0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      fre_add_r_a <= 1'b1;
      fre_add_r_b <= 1'b1;
    end else begin
      state       <= state_nxt;
      frame_ok    <= (state == APPLY);
      frame_err   <= err_nxt;
      busy        <= (state_nxt != IDLE);
      fre_add_r_a <= !((state == APPLY) && (cmd_q[3:0] == OP_SYNC));
      fre_add_r_b <= !((state == APPLY) && (cmd_q[3:0] == OP_SYNC));
      if (state == IDLE || state == APPLY || rx_valid) tcnt <= 24'd0;
      else                                            tcnt <= tcnt + 24'd1;
      if (rx_valid && !timeout) begin
        if (state == CMD)      byte_cnt <= 2'd0;
        else if (state == PAY) byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // Frame capture: command, payload shift register and running checksum
  always_ff @(posedge sys_clk) begin
    if (rx_valid && !timeout) begin
      if (state == CMD) begin
        cmd_q  <= rx_data;
        ck_acc <= rx_data;
      end else if (state == PAY) begin
        pay_q  <= {pay_q[23:0], rx_data};
        ck_acc <= ck_acc ^ rx_data;
      end
    end
  end

  dds_chan_regs #(
    .FREQ_RST  (FREQ_RST),
    .PHASE_RST (PHASE_RST)
  ) u_regs_a (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .we         ((state == APPLY) && !cmd_q[4]),
    .op         (cmd_q[3:0]),
    .payload    (pay_q),
    .freq_ctrl  (freq_ctrl_a),
    .phase_ctrl (phase_ctrl_a),
    .wave_sel   (wave_sel_a)
  );

  dds_chan_regs #(
    .FREQ_RST  (FREQ_RST),
    .PHASE_RST (PHASE_RST)
  ) u_regs_b (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .we         ((state == APPLY) && cmd_q[4]),
    .op         (cmd_q[3:0]),
    .payload    (pay_q),
    .freq_ctrl  (freq_ctrl_b),
    .phase_ctrl (phase_ctrl_b),
    .wave_sel   (wave_sel_b)
  );

endmodule
